// File: rtl/multiplicador_pkg.sv
// Shared types and sizes for the multiplicador shift-add multiplier.
package multiplicador_pkg;

  localparam int unsigned LARGURA_MUL  = 16;
  localparam int unsigned N_PASSOS     = 16;
  localparam int unsigned LARGURA_CONT = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIM
  } estado_t;

endpackage

// File: rtl/multiplicador_nucleo.sv
// Unsigned radix-2 shift-add datapath: one partial-product step per enabled edge.
module multiplicador_nucleo
  import multiplicador_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_MUL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_carregar,
  input  logic                   i_passo,
  input  logic [LARGURA-1:0]     i_multiplicando,
  input  logic [LARGURA-1:0]     i_multiplicador,
  output logic [2*LARGURA-1:0]   o_produto,
  output logic                   o_ultimo
);

  logic [LARGURA-1:0]      r_mcand;
  logic [2*LARGURA-1:0]    r_acc;
  logic [LARGURA_CONT-1:0] r_cont;
  logic [LARGURA:0]        w_parcela;
  logic [LARGURA:0]        w_soma;

  // Upper half accumulates; lower half starts as the multiplier and shifts out its LSB.
  assign w_parcela = r_acc[0] ? {1'b0, r_mcand} : '0;
  assign w_soma    = {1'b0, r_acc[2*LARGURA-1:LARGURA]} + w_parcela;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_cont  <= '0;
    end else if (i_carregar) begin
      r_mcand <= i_multiplicando;
      r_acc   <= {{LARGURA{1'b0}}, i_multiplicador};
      r_cont  <= '0;
    end else if (i_passo) begin
      r_acc   <= {w_soma, r_acc[LARGURA-1:1]};
      r_cont  <= r_cont + LARGURA_CONT'(1);
    end
  end

  assign o_produto = r_acc;
  assign o_ultimo  = (r_cont == LARGURA_CONT'(N_PASSOS - 1));

endmodule

// File: rtl/multiplicador.sv
// Sequential 16x16 multiplier: FSM, sign handling and output registers.
// Define MULTIPLICADOR_SINAL_EN to honour com_sinal (two's-complement operands).
module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_MUL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               com_sinal,
  input  logic [LARGURA-1:0] operando1,
  input  logic [LARGURA-1:0] operando2,
  output logic [LARGURA-1:0] mulH,
  output logic [LARGURA-1:0] mulL,
  output logic               busy,
  output logic               done
);

  estado_t                r_estado, w_estado_prox;
  logic                   w_carregar, w_passo, w_escrever, w_ultimo;
  logic [LARGURA-1:0]     w_mag1, w_mag2;
  logic [2*LARGURA-1:0]   w_produto, w_resultado;
  logic [LARGURA-1:0]     r_mulH, r_mulL;
  logic                   r_done;

`ifdef MULTIPLICADOR_SINAL_EN
  logic r_negar;

  // 0x8000 maps to 32768, which still fits the unsigned magnitude.
  assign w_mag1 = (com_sinal && operando1[LARGURA-1]) ? LARGURA'(-operando1) : operando1;
  assign w_mag2 = (com_sinal && operando2[LARGURA-1]) ? LARGURA'(-operando2) : operando2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_negar <= 1'b0;
    end else if (w_carregar) begin
      r_negar <= com_sinal & (operando1[LARGURA-1] ^ operando2[LARGURA-1]);
    end
  end

  // Negating a zero product yields zero, so no separate nonzero test is needed.
  assign w_resultado = r_negar ? -w_produto : w_produto;
`else
  logic w_unused_sinal;

  assign w_unused_sinal = com_sinal;
  assign w_mag1         = operando1;
  assign w_mag2         = operando2;
  assign w_resultado    = w_produto;
`endif

  multiplicador_nucleo #(
    .LARGURA (LARGURA)
  ) u_nucleo (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_carregar      (w_carregar),
    .i_passo         (w_passo),
    .i_multiplicando (w_mag1),
    .i_multiplicador (w_mag2),
    .o_produto       (w_produto),
    .o_ultimo        (w_ultimo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_carregar    = 1'b0;
    w_passo       = 1'b0;
    w_escrever    = 1'b0;
    case (r_estado)
      IDLE: begin
        if (start) begin
          w_carregar    = 1'b1;
          w_estado_prox = CALC;
        end
      end
      CALC: begin
        w_passo = 1'b1;
        if (w_ultimo) begin
          w_estado_prox = FIM;
        end
      end
      FIM: begin
        w_escrever    = 1'b1;
        w_estado_prox = IDLE;
      end
      default: w_estado_prox = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mulH <= '0;
      r_mulL <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_escrever;
      if (w_escrever) begin
        r_mulH <= w_resultado[2*LARGURA-1:LARGURA];
        r_mulL <= w_resultado[LARGURA-1:0];
      end
    end
  end

  assign mulH = r_mulH;
  assign mulL = r_mulL;
  assign done = r_done;
  assign busy = (r_estado != IDLE);

endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador with a scoreboard queue of expected products.
module tb_multiplicador;

`ifdef MULTIPLICADOR_SINAL_EN
  localparam bit SINAL_EN = 1'b1;
`else
  localparam bit SINAL_EN = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        start     = 1'b0;
  logic        com_sinal = 1'b0;
  logic [15:0] operando1 = '0;
  logic [15:0] operando2 = '0;
  logic [15:0] mulH, mulL;
  logic        busy, done;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] fila[$];

  always #5 clk = ~clk;

  multiplicador dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .com_sinal (com_sinal),
    .operando1 (operando1),
    .operando2 (operando2),
    .mulH      (mulH),
    .mulL      (mulL),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [31:0] modelo(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    if (s && SINAL_EN) r = sa * sb;
    else               r = {16'b0, a} * {16'b0, b};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge just after E0 (cycle 0 of the operation).
  task automatic disparar(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    operando1 = a;
    operando2 = b;
    com_sinal = s;
    start     = 1'b1;
    @(posedge clk);
    fila.push_back(modelo(a, b, s));
    @(negedge clk);
    start     = 1'b0;
    operando1 = 16'($urandom);
    operando2 = 16'($urandom);
    com_sinal = ~s;
    chk("busy after E0", {31'b0, busy}, 32'd1);
  endtask

  // Returns at the negedge of the done cycle so the caller can start back-to-back.
  task automatic esperar_done(input int c0, input string tag);
    int          cyc      = c0;
    bit          visto    = 1'b0;
    bit          sobrepos = 1'b0;
    logic [31:0] esp;
    while (!visto && cyc < c0 + 40) begin
      @(negedge clk);
      cyc++;
      if (busy && done) sobrepos = 1'b1;
      if (done) visto = 1'b1;
    end
    chk({tag, " done seen"}, {31'b0, visto}, 32'd1);
    chk({tag, " busy/done overlap"}, {31'b0, sobrepos}, 32'd0);
    if (visto && fila.size() > 0) begin
      esp = fila.pop_front();
      chk({tag, " latency"}, 32'(cyc), 32'd17);
      chk({tag, " mulH"}, {16'b0, mulH}, {16'b0, esp[31:16]});
      chk({tag, " mulL"}, {16'b0, mulL}, {16'b0, esp[15:0]});
      chk({tag, " busy in done cycle"}, {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s,
                    input string tag);
    disparar(a, b, s);
    esperar_done(0, tag);
  endtask

  initial begin
    bit d;

    #2 rst_n = 1'b0;
    #1;
    chk("reset mulH", {16'b0, mulH}, 32'd0);
    chk("reset mulL", {16'b0, mulL}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(16'h0003, 16'h0005, 1'b0, "u 3x5");
    op(16'hFFFF, 16'hFFFF, 1'b0, "u FFFFxFFFF");
    op(16'h0000, 16'h1234, 1'b0, "u zero");
    op(16'hFFFD, 16'h0005, 1'b1, "s FFFDx0005");
    op(16'h8000, 16'h8000, 1'b1, "s 8000x8000");
    op(16'hFFFF, 16'hFFFF, 1'b1, "s FFFFxFFFF");
    op(16'hFFFF, 16'h0002, 1'b1, "s FFFFx0002");
    op(16'h8000, 16'h0001, 1'b1, "s 8000x0001");
    op(16'h0000, 16'hFFFF, 1'b1, "s zero");

    // start at E5 must be ignored; start in the done cycle must be accepted
    disparar(16'h0102, 16'h0304, 1'b0);
    repeat (4) @(negedge clk);
    operando1 = 16'h0007;
    operando2 = 16'h0007;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    esperar_done(5, "b2b first");
    operando1 = 16'h00AB;
    operando2 = 16'h0100;
    com_sinal = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    fila.push_back(modelo(16'h00AB, 16'h0100, 1'b0));
    @(negedge clk);
    start = 1'b0;
    esperar_done(0, "b2b second");

    // Abort at E8: no scoreboard entry, outputs clear immediately
    @(negedge clk);
    operando1 = 16'h1234;
    operando2 = 16'h0010;
    com_sinal = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort mulH", {16'b0, mulH}, 32'd0);
    chk("abort mulL", {16'b0, mulL}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) d = 1'b1;
    end
    chk("abort no done", {31'b0, d}, 32'd0);
    op(16'h0002, 16'h0002, 1'b0, "after reset 2x2");

    chk("scoreboard empty", 32'(fila.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplicador.md
MULTIPLICADOR -- requirements
Module: multiplicador

Interface
REQ-001 SHALL have parameter LARGURA, default 16, operand width; only 16 is required to work.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port com_sinal  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port operando1  input  16  multiplicand.
REQ-007 SHALL have port operando2  input  16  multiplier.
REQ-008 SHALL have port mulH  output  16  product bits 31:16, registered; feeds ALU codop 13.
REQ-009 SHALL have port mulL  output  16  product bits 15:0, registered; feeds ALU codop 14.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when mulH/mulL are updated.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and FIM.
REQ-013 IDLE with start=1 at edge E0 SHALL latch operands and com_sinal, clear the accumulator, and go to CALC.
REQ-014 CALC SHALL run one radix-2 shift-add step per edge, E1..E16, on the operand magnitudes, using a 5-bit counter.
REQ-015 After the 16th step, CALC SHALL go to FIM.
REQ-016 FIM at edge E17 SHALL apply sign correction, write mulH/mulL, set done=1 for one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed at 17 cycles from the start-sampling edge to done, independent of operand values, including 0.
REQ-018 busy SHALL be 1 from after E0 until after E17; busy and done SHALL never be high together.
REQ-019 start while busy=1 SHALL be ignored; no queuing.
REQ-020 start during the done cycle SHALL be accepted, giving back-to-back operations with an 18-cycle period.
REQ-021 mulH/mulL SHALL hold the last result until the next FIM; operand changes after E0 SHALL have no effect.
REQ-022 Signed mode: magnitudes SHALL be computed as 16-bit unsigned, so 0x8000 gives 32768; the 32-bit product SHALL be negated iff the operand signs differ and the product is nonzero.
REQ-023 Unsigned mode SHALL produce the exact 32-bit product; no overflow or saturation is possible.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, mulH=0, mulL=0, busy=0, done=0, counter=0, accumulator=0.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro MULTIPLICADOR_SINAL_EN defined: com_sinal SHALL be honoured per REQ-022.
REQ-027 MULTIPLICADOR_SINAL_EN undefined: com_sinal SHALL be ignored, all operations SHALL be unsigned, and sign-correction logic SHALL be absent; latency is unchanged.

Structure
REQ-028 Package multiplicador_pkg SHALL hold the state enum (IDLE/CALC/FIM), LARGURA_MUL=16 and N_PASSOS=16.
REQ-029 The unsigned shift-add datapath SHALL be a sub-module, multiplicador_nucleo (accumulator, shift, counter); the FSM, sign handling and output registers SHALL stay in multiplicador.

Verification
REQ-030 Unsigned 3 x 5, start at E0 -> done at E17, mulH=0x0000, mulL=0x000F.
REQ-031 Unsigned 0xFFFF x 0xFFFF -> mulH=0xFFFE, mulL=0x0001.
REQ-032 Signed: 0xFFFD x 0x0005 -> 0xFFFF/0xFFF1; 0x8000 x 0x8000 -> 0x4000/0x0000; 0xFFFF x 0xFFFF -> 0x0000/0x0001.
REQ-033 start pulsed at E0 and E5, then again in the done cycle -> E5 ignored; the second result arrives 17 cycles after the done cycle; busy/done never overlap.
REQ-034 rst_n low at E8 of 0x1234 x 0x0010 -> outputs 0 at once, no done; a new 2 x 2 after release -> mulL=0x0004 at E17.
REQ-035 Build without MULTIPLICADOR_SINAL_EN, com_sinal=1, 0xFFFF x 0x0002 -> mulH=0x0001, mulL=0xFFFE.
